conv_io_master: RTL and testbench



---
 rtl/conv_io_pkg.sv | 19 +
 rtl/conv_stream_tx.sv | 57 +++++
 rtl/conv_io_master.sv | 131 +++++++++++++
 tb/tb_conv_io_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_io_pkg.sv
// rtl/conv_io_pkg.sv - shared state encoding and size helpers for the convolution I/O master
package conv_io_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int DEF_X_SIZE = 128;
    localparam int DEF_F_SIZE = 32;
    localparam int Y_SIZE     = DEF_X_SIZE - DEF_F_SIZE + 1;

    function automatic int y_len(input int xs, input int fs);
        return xs - fs + 1;
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/conv_stream_tx.sv
// rtl/conv_stream_tx.sv - preloaded element buffer streamed out once per run over valid/ready
module conv_stream_tx #(
    parameter int W    = 8,
    parameter int SIZE = 128,
    localparam int AW  = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          launch,
    input  logic          stop,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          sent
);

    logic [W-1:0]  mem_q [SIZE];
    logic [AW-1:0] idx_q;
    logic          valid_q;
    logic          sent_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            sent_q  <= 1'b0;
        end else if (launch) begin
            idx_q   <= '0;
            valid_q <= 1'b1;
            sent_q  <= 1'b0;
        end else if (stop) begin
            valid_q <= 1'b0;
        end else if (valid_q && m_ready) begin
            // The index parks on the last element; valid going low marks the end.
            if (idx_q == AW'(SIZE - 1)) begin
                valid_q <= 1'b0;
                sent_q  <= 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign m_valid = valid_q;
    assign m_data  = mem_q[idx_q];
    assign sent    = sent_q;

endmodule

// File: rtl/conv_io_master.sv
// rtl/conv_io_master.sv - streams X/F vectors into the convolution core and captures its Y results
module conv_io_master
    import conv_io_pkg::*;
#(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_F = 8,
    parameter int X_SIZE       = DEF_X_SIZE,
    parameter int F_SIZE       = DEF_F_SIZE,
    parameter int ACC_SIZE     = 21,
    localparam int YS          = y_len(X_SIZE, F_SIZE),
    localparam int XAW         = $clog2(X_SIZE),
    localparam int FAW         = $clog2(F_SIZE),
    localparam int YAW         = $clog2(YS),
    localparam int YCW         = cnt_w(YS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_wr_en,
    input  logic                    ld_sel,
    input  logic [XAW-1:0]          ld_addr,
    input  logic [DATA_WIDTH_X-1:0] ld_data,
    input  logic                    start,
    input  logic                    y_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    m_valid_x,
    input  logic                    m_ready_x,
    output logic [DATA_WIDTH_X-1:0] m_data_x,
    output logic                    m_valid_f,
    input  logic                    m_ready_f,
    output logic [DATA_WIDTH_F-1:0] m_data_f,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    input  logic [ACC_SIZE-1:0]     s_data_y,
    input  logic [YAW-1:0]          rd_addr,
    output logic [ACC_SIZE-1:0]     rd_data,
    output logic [YCW-1:0]          y_count
);

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [YCW-1:0]      y_count_q;
    logic [ACC_SIZE-1:0] ybuf_q [YS];

    logic in_idle, launch, load_en, y_hs, y_last, x_sent, f_sent;

    assign in_idle   = (state_q == IDLE);
    assign launch    = in_idle & start;
    assign load_en   = in_idle & ld_wr_en;
    assign s_ready_y = (state_q == RUN) & ~y_hold & (y_count_q < YCW'(YS));
    assign y_hs      = s_valid_y & s_ready_y;
    assign y_last    = y_hs & (y_count_q == YCW'(YS - 1));

    conv_stream_tx #(.W(DATA_WIDTH_X), .SIZE(X_SIZE)) u_tx_x (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (load_en & ~ld_sel),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .launch  (launch),
        .stop    (y_last & ~x_sent),
        .m_valid (m_valid_x),
        .m_ready (m_ready_x),
        .m_data  (m_data_x),
        .sent    (x_sent)
    );

    conv_stream_tx #(.W(DATA_WIDTH_F), .SIZE(F_SIZE)) u_tx_f (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (load_en & ld_sel),
        .wr_addr (ld_addr[FAW-1:0]),
        .wr_data (ld_data[DATA_WIDTH_F-1:0]),
        .launch  (launch),
        .stop    (y_last & ~f_sent),
        .m_valid (m_valid_f),
        .m_ready (m_ready_f),
        .m_data  (m_data_f),
        .sent    (f_sent)
    );

    always_ff @(posedge clk) begin
        if (y_hs) begin
            ybuf_q[y_count_q[YAW-1:0]] <= s_data_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        y_count_q <= '0;
                    end
                end
                RUN: begin
                    if (y_hs) begin
                        y_count_q <= y_count_q + 1'b1;
                    end
                    if (y_last) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign y_count = y_count_q;
    assign rd_data = ({1'b0, rd_addr} < (YAW + 1)'(YS)) ? ybuf_q[rd_addr] : '0;

endmodule

// File: tb/tb_conv_io_master.sv
// tb/tb_conv_io_master.sv - randomized self-checking bench with a behavioural convolution core
module tb_conv_io_master;

    localparam int XS = 128;
    localparam int FS = 32;
    localparam int YS = 97;

    logic        clk = 1'b0;
    logic        reset, ld_wr_en, ld_sel, start, y_hold;
    logic [6:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        busy, done;
    logic        m_valid_x, m_ready_x, m_valid_f, m_ready_f;
    logic [7:0]  m_data_x, m_data_f;
    logic        s_valid_y, s_ready_y;
    logic [20:0] s_data_y, rd_data;
    logic [6:0]  rd_addr, y_count;

    conv_io_master dut (
        .clk(clk), .reset(reset), .ld_wr_en(ld_wr_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .y_hold(y_hold),
        .busy(busy), .done(done),
        .m_valid_x(m_valid_x), .m_ready_x(m_ready_x), .m_data_x(m_data_x),
        .m_valid_f(m_valid_f), .m_ready_f(m_ready_f), .m_data_f(m_data_f),
        .s_valid_y(s_valid_y), .s_ready_y(s_ready_y), .s_data_y(s_data_y),
        .rd_addr(rd_addr), .rd_data(rd_data), .y_count(y_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 finishing.
    logic [7:0]  xm [XS];
    logic [7:0]  fm [FS];
    logic [20:0] ym [YS];
    bit          yw [YS];
    int          phase = 0, xi = 0, fi = 0, yc = 0;
    bit          xv = 0, fv = 0;
    bit          chk_en = 0;

    function automatic int mconv(input int k);
        int s = 0;
        for (int j = 0; j < FS; j++) s += int'($signed(xm[k + j])) * int'($signed(fm[j]));
        return s;
    endfunction

    always @(posedge clk) begin : model
        bit xhs, fhs, yhs;
        xhs = xv && m_ready_x;
        fhs = fv && m_ready_f;
        yhs = (phase == 1) && !y_hold && (yc < YS) && s_valid_y;
        if (reset) begin
            phase = 0; xi = 0; fi = 0; yc = 0; xv = 0; fv = 0;
        end else begin
            case (phase)
                0: begin
                    if (ld_wr_en) begin
                        if (ld_sel) fm[ld_addr[4:0]] = ld_data;
                        else        xm[ld_addr] = ld_data;
                    end
                    if (start) begin
                        phase = 1; xi = 0; fi = 0; yc = 0; xv = 1; fv = 1;
                    end
                end
                1: begin
                    if (xhs) begin xi++; if (xi == XS) xv = 0; end
                    if (fhs) begin fi++; if (fi == FS) fv = 0; end
                    if (yhs) begin
                        ym[yc] = s_data_y; yw[yc] = 1; yc++;
                        if (yc == YS) begin phase = 2; xv = 0; fv = 0; end
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("busy", busy, phase == 1);
            check("done", done, phase == 2);
            check("m_valid_x", m_valid_x, xv);
            check("m_valid_f", m_valid_f, fv);
            if (xv) check("m_data_x", m_data_x, xm[xi]);
            if (fv) check("m_data_f", m_data_f, fm[fi]);
            check("s_ready_y", s_ready_y, (phase == 1) && !y_hold && (yc < YS));
            check("y_count", y_count, yc);
            if (rd_addr < YS && yw[rd_addr]) check("rd_data", rd_data, ym[rd_addr]);
        end
    end

    // Behavioural convolution core on the far side of the streams.
    logic [7:0] cx [XS];
    logic [7:0] cf [FS];
    int cxn = 0, cfn = 0, cyn = 0;
    int rmode = 0;
    bit junk = 0;

    function automatic int cconv(input int k);
        int s = 0;
        for (int j = 0; j < FS; j++) s += int'($signed(cx[k + j])) * int'($signed(cf[j]));
        return s;
    endfunction

    always @(posedge clk) begin : core
        bit have;
        int v;
        if (m_valid_x && m_ready_x && cxn < XS) begin cx[cxn] = m_data_x; cxn++; end
        if (m_valid_f && m_ready_f && cfn < FS) begin cf[cfn] = m_data_f; cfn++; end
        if (s_valid_y && s_ready_y) cyn++;
        #1;
        case (rmode)
            0: begin m_ready_x = 1'b1; m_ready_f = 1'b1; end
            1: begin m_ready_x = ~m_ready_x; m_ready_f = 1'b1; end
            default: begin m_ready_x = 1'($urandom); m_ready_f = 1'($urandom); end
        endcase
        have = (cfn == FS) && (cyn < YS) && (cxn >= cyn + FS);
        v = have ? cconv(cyn) : int'($urandom);
        s_valid_y = have | junk;
        s_data_y  = v[20:0];
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input bit sel, input int addr, input int data);
        ld_wr_en = 1'b1; ld_sel = sel; ld_addr = 7'(addr); ld_data = 8'(data);
        tick();
        ld_wr_en = 1'b0;
    endtask

    // pat: 0 random, 1 all ones, 2 ramp with unit impulse filter
    task automatic load_all(input int pat);
        for (int i = 0; i < XS; i++)
            load(1'b0, i, pat == 1 ? 1 : pat == 2 ? i - 64 : int'($urandom_range(0, 255)));
        for (int j = 0; j < FS; j++)
            load(1'b1, j, pat == 1 ? 1 : pat == 2 ? (j == 0 ? 1 : 0) : int'($urandom_range(0, 255)));
    endtask

    task automatic run(input int hold_at, input bit mid_ops, input int lit);
        int dones = 0;
        int bad = 0;
        int c;
        cxn = 0; cfn = 0; cyn = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            y_hold = (hold_at >= 0) && (c >= hold_at) && (c < hold_at + 10);
            if (mid_ops && c == 3) begin
                start = 1'b1; ld_wr_en = 1'b1; ld_sel = 1'b0; ld_addr = 7'd5; ld_data = ~xm[5];
            end else begin
                start = 1'b0; ld_wr_en = 1'b0;
            end
            if (done) dones++;
            if (done) break;
        end
        y_hold = 1'b0; start = 1'b0; ld_wr_en = 1'b0;
        @(negedge clk);
        if (done) dones++;
        check("done_pulses", dones, 1);
        check("final_y_count", y_count, 97);
        check("x_handshakes", cxn, XS);
        check("f_handshakes", cfn, FS);
        for (int i = 0; i < XS; i++) if (cx[i] !== xm[i]) bad++;
        for (int j = 0; j < FS; j++) if (cf[j] !== fm[j]) bad++;
        check("stream_order", bad, 0);
        for (int k = 0; k < YS; k++) begin
            rd_addr = 7'(k);
            #1;
            check("ybuf_vs_conv", longint'($signed(rd_data)), mconv(k));
            if (lit == 1) check("ybuf_all_ones", longint'($signed(rd_data)), 32);
            if (lit == 2) check("ybuf_ramp", longint'($signed(rd_data)), k - 64);
        end
    endtask

    initial begin
        int c;
        reset = 1'b1; ld_wr_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; y_hold = 1'b0; rd_addr = '0;
        m_ready_x = 1'b0; m_ready_f = 1'b0; s_valid_y = 1'b0; s_data_y = '0;
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid_x", m_valid_x, 0);
        check("rst_valid_f", m_valid_f, 0);
        check("rst_ready_y", s_ready_y, 0);
        check("rst_y_count", y_count, 0);
        reset = 1'b0;

        load_all(1);
        run(-1, 1'b0, 1);

        load_all(2);
        run(-1, 1'b0, 2);

        load_all(0);
        junk = 1;
        repeat (5) tick();
        junk = 0;
        rmode = 1;
        run(-1, 1'b0, 0);

        rmode = 2;
        run(60, 1'b0, 0);

        rmode = 0;
        begin
            logic [7:0] x5;
            x5 = xm[5];
            run(-1, 1'b1, 0);
            run(-1, 1'b0, 0);
            check("xbuf5_kept", cx[5], x5);
        end

        cxn = 0; cfn = 0; cyn = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (c = 0; c < 500 && cxn < 40; c++) @(negedge clk);
        check("reach_40_x", cxn >= 40, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid_x", m_valid_x, 0);
        check("abort_busy", busy, 0);
        check("abort_y_count", y_count, 0);
        reset = 1'b0;
        tick();
        run(-1, 1'b0, 0);
        check("restart_elem0", cx[0], xm[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
